// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// The PARITY state only exists when SIPO_PARITY_EN is defined.
package sipo_pkg;

  localparam int SIPO_DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SIPO_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } sipo_state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial shift register with clear and a look-ahead parallel output.
// o_word shows the register contents as they will be after this cycle's
// shift, so the owner can capture a completed word on the same edge that
// samples its last bit.
module sipo_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift_en,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;

  // MSB-first shifts toward the top so the first bit ends in [WIDTH-1];
  // LSB-first shifts toward the bottom so the first bit ends in [0].
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {r_data[WIDTH-2:0], i_sin};
    end else begin : g_lsb_first
      assign w_shifted = {i_sin, r_data[WIDTH-1:1]};
    end
  endgenerate

  // Look-ahead view: the shifted value while shifting, the stored value otherwise.
  always_comb begin
    o_word = r_data;
    if (i_shift_en) begin
      o_word = w_shifted;
    end
  end

  // Storage: clear wins over shift so an aborted frame leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_shift_en) begin
      r_data <= w_shifted;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-word output register,
// ready/valid handoff and a sticky overrun flag.
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit
// per frame, the PARITY state and the parity_err output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             q_ready,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sipo_state_t      r_state;
  sipo_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift_en;
  logic             w_clear;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_overrun;
`ifdef SIPO_PARITY_EN
  logic             w_perr;
  logic             r_parity_err;
`endif

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_shift_en (w_shift_en),
    .i_sin      (sin),
    .o_word     (w_word)
  );

`ifdef SIPO_PARITY_EN
  // Even parity over data plus parity bit: any odd total is a mismatch.
  assign w_perr = ^{w_word, sin};
`endif

  // State and bit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter update and shift/clear/complete strobes; start always
  // takes priority over a data bit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_clear     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_clear     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          w_cnt_nxt = '0;
          w_clear   = 1'b1;
        end else if (sin_en) begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_IDLE;
            w_complete  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      ST_PARITY: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_clear     = 1'b1;
        end else if (sin_en) begin
          w_state_nxt = ST_IDLE;
          w_complete  = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output word register: load on completion if the slot is free or being
  // consumed this cycle, otherwise drop the new word and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= '0;
      r_q_valid    <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else if (w_complete) begin
      if (!r_q_valid || q_ready) begin
        r_q          <= w_word;
        r_q_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
        r_parity_err <= w_perr;
`endif
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_q_valid && q_ready) begin
      r_q_valid <= 1'b0;
    end
  end

  assign Q       = r_q;
  assign q_valid = r_q_valid;
  assign overrun = r_overrun;
  assign busy    = (r_state != ST_IDLE);
`ifdef SIPO_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: an MSB-first and an LSB-first instance share all
// inputs. Expected words are queued when a frame is sent and popped by a
// monitor on every accepted handoff (q_valid && q_ready).
// Honours SIPO_PARITY_EN: frames then carry a trailing parity bit.
module tb_sipo_deser;

  typedef struct packed {
    logic [3:0] word;
    logic       perr;
  } expT;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       sin    = 1'b0;
  logic       sinEn  = 1'b0;
  logic       qReady = 1'b1;
  logic [3:0] qM;
  logic [3:0] qL;
  logic       qValidM;
  logic       qValidL;
  logic       busyM;
  logic       busyL;
  logic       overrunM;
  logic       overrunL;
`ifdef SIPO_PARITY_EN
  logic       parityErrM;
  logic       parityErrL;
`endif

  int  checks = 0;
  int  errors = 0;
  expT expM[$];
  expT expL[$];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dutMsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sin        (sin),
    .sin_en     (sinEn),
    .q_ready    (qReady),
    .Q          (qM),
    .q_valid    (qValidM),
    .busy       (busyM),
    .overrun    (overrunM)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (parityErrM)
`endif
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dutLsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sin        (sin),
    .sin_en     (sinEn),
    .q_ready    (qReady),
    .Q          (qL),
    .q_valid    (qValidL),
    .busy       (busyL),
    .overrun    (overrunL)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (parityErrL)
`endif
  );

  // One comparison: counts it, reports a failure with actual and required values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic st, input logic en, input logic b);
    start = st;
    sinEn = en;
    sin   = b;
    @(posedge clk);
    #1;
  endtask

  // Compare the visible outputs of both instances.
  task automatic checkBoth(input string name, input logic [3:0] expQM, input logic [3:0] expQL,
                           input logic v, input logic b, input logic o);
    checkOutput({name, " Q msb"},       32'(qM),       32'(expQM));
    checkOutput({name, " Q lsb"},       32'(qL),       32'(expQL));
    checkOutput({name, " q_valid msb"}, 32'(qValidM),  32'(v));
    checkOutput({name, " q_valid lsb"}, 32'(qValidL),  32'(v));
    checkOutput({name, " busy msb"},    32'(busyM),    32'(b));
    checkOutput({name, " busy lsb"},    32'(busyL),    32'(b));
    checkOutput({name, " overrun msb"}, 32'(overrunM), 32'(o));
    checkOutput({name, " overrun lsb"}, 32'(overrunL), 32'(o));
  endtask

  // Send start plus four bits (first bit = f[3]), with optional idle gaps
  // carrying the inverted bit on sin; flip corrupts the parity bit.
  task automatic sendFrame(input logic [3:0] f, input int gap, input logic push,
                           input logic [3:0] wM, input logic [3:0] wL, input logic flip);
    expT e;
    if (push) begin
      e.word = wM;
      e.perr = flip;
      expM.push_back(e);
      e.word = wL;
      expL.push_back(e);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      repeat (gap) applyStimulus(1'b0, 1'b0, ~f[i]);
      applyStimulus(1'b0, 1'b1, f[i]);
    end
`ifdef SIPO_PARITY_EN
    applyStimulus(1'b0, 1'b1, (^f) ^ flip);
`endif
    start = 1'b0;
    sinEn = 1'b0;
    sin   = 1'b0;
  endtask

  // Monitor: every accepted word must match the head of its scoreboard queue.
  always @(negedge clk) begin : monitor
    expT e;
    if (rst_n) begin
      if (qValidM && qReady) begin
        if (expM.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb msb: got unexpected word 0x%0h, required none", qM);
        end else begin
          e = expM.pop_front();
          checkOutput("sb msb word", 32'(qM), 32'(e.word));
`ifdef SIPO_PARITY_EN
          checkOutput("sb msb parity_err", 32'(parityErrM), 32'(e.perr));
`endif
        end
      end
      if (qValidL && qReady) begin
        if (expL.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb lsb: got unexpected word 0x%0h, required none", qL);
        end else begin
          e = expL.pop_front();
          checkOutput("sb lsb word", 32'(qL), 32'(e.word));
`ifdef SIPO_PARITY_EN
          checkOutput("sb lsb parity_err", 32'(parityErrL), 32'(e.perr));
`endif
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkBoth("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("[TB] basic frames, q_ready=1");
    sendFrame(4'b1011, 0, 1'b1, 4'hB, 4'hD, 1'b0);
    checkBoth("frame 1011", 4'hB, 4'hD, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkBoth("after consume", 4'hB, 4'hD, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b1011, 2, 1'b1, 4'hB, 4'hD, 1'b0);
    checkBoth("gapped 1011", 4'hB, 4'hD, 1'b1, 1'b0, 1'b0);
    sendFrame(4'b0110, 1, 1'b1, 4'h6, 4'h6, 1'b0);
    checkBoth("frame 0110", 4'h6, 4'h6, 1'b1, 1'b0, 1'b0);
    sendFrame(4'b0011, 0, 1'b1, 4'h3, 4'hC, 1'b0);
    checkBoth("frame 0011", 4'h3, 4'hC, 1'b1, 1'b0, 1'b0);
    sendFrame(4'b1000, 0, 1'b1, 4'h8, 4'h1, 1'b0);
    checkBoth("frame 1000", 4'h8, 4'h1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkBoth("sin_en in idle", 4'h8, 4'h1, 1'b0, 1'b0, 1'b0);

    $display("[TB] overrun with q_ready=0");
    qReady = 1'b0;
    sendFrame(4'b1011, 0, 1'b1, 4'hB, 4'hD, 1'b0);
    checkBoth("held 1011", 4'hB, 4'hD, 1'b1, 1'b0, 1'b0);
    sendFrame(4'b0110, 0, 1'b0, 4'h6, 4'h6, 1'b0);
    checkBoth("discarded 0110", 4'hB, 4'hD, 1'b1, 1'b0, 1'b1);
    qReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkBoth("drain after overrun", 4'hB, 4'hD, 1'b0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mid-frame busy msb", 32'(busyM), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkBoth("async reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    checkOutput("async reset parity_err", 32'(parityErrM), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1);
    checkBoth("bits without start", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] abort by start");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkBoth("partial frame", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    sendFrame(4'b0110, 0, 1'b1, 4'h6, 4'h6, 1'b0);
    checkBoth("abort then 0110", 4'h6, 4'h6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    $display("[TB] parity");
    sendFrame(4'b1011, 0, 1'b1, 4'hB, 4'hD, 1'b0);
    checkOutput("good parity err msb", 32'(parityErrM), 32'd0);
    checkOutput("good parity Q msb", 32'(qM), 32'hB);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendFrame(4'b1011, 0, 1'b1, 4'hB, 4'hD, 1'b1);
    checkOutput("bad parity err msb", 32'(parityErrM), 32'd1);
    checkOutput("bad parity err lsb", 32'(parityErrL), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sb drained msb", 32'(expM.size()), 32'd0);
    checkOutput("sb drained lsb", 32'(expL.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
